// File: rtl/decoder_n_scan.sv
// decoder_n_scan: registered N-to-2^N one-hot decoder with output enable and an
// auto-scan mode that walks every output in turn, holding each for DWELL cycles.
module decoder_n_scan #(
  parameter int unsigned N     = 3,
  parameter int unsigned DWELL = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_enable,
  input  logic               i_mode,
  input  logic [N-1:0]       i_addr,
  input  logic               i_load,
  output logic [(1<<N)-1:0]  o_y,
  output logic [N-1:0]       o_idx,
  output logic               o_wrap
);

  localparam int unsigned W  = 1 << N;
  localparam int unsigned CW = (DWELL > 1) ? $clog2(DWELL) : 1;

  localparam logic [CW-1:0] CntLast = CW'(DWELL - 1);
  localparam logic [N-1:0]  IdxLast = {N{1'b1}};

  logic [N-1:0]  r_idx;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_y;
  logic          r_wrap;

  logic [N-1:0]  w_idx_next;
  logic [CW-1:0] w_cnt_next;
  logic          w_wrap_next;
  logic [W-1:0]  w_y_next;

  // Next index / dwell count / wrap, in mode-then-load-then-enable priority.
  always_comb begin
    w_idx_next  = r_idx;
    w_cnt_next  = r_cnt;
    w_wrap_next = 1'b0;
    if (!i_mode) begin
      w_idx_next = i_addr;
      w_cnt_next = '0;
    end else if (i_load) begin
      // Load is honoured even while disabled.
      w_idx_next = i_addr;
      w_cnt_next = '0;
    end else if (!i_enable) begin
      // Freeze scan position and remaining dwell.
      w_idx_next = r_idx;
      w_cnt_next = r_cnt;
    end else if (r_cnt == CntLast) begin
      w_idx_next  = r_idx + N'(1);
      w_cnt_next  = '0;
      w_wrap_next = (r_idx == IdxLast);
    end else begin
      w_cnt_next = r_cnt + CW'(1);
    end
  end

  // One-hot decode of the next index, gated by enable.
  always_comb begin
    w_y_next = '0;
    if (i_enable) begin
      w_y_next = {{(W-1){1'b0}}, 1'b1} << w_idx_next;
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_idx  <= '0;
      r_cnt  <= '0;
      r_y    <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_idx  <= w_idx_next;
      r_cnt  <= w_cnt_next;
      r_y    <= w_y_next;
      r_wrap <= w_wrap_next;
    end
  end

  assign o_y    = r_y;
  assign o_idx  = r_idx;
  assign o_wrap = r_wrap;

endmodule

// File: tb/tb_decoder_n_scan.sv
// Directed self-checking bench for decoder_n_scan: N=3/DWELL=4 main instance
// plus an N=1/DWELL=1 instance for the single-cycle dwell edge case.
module tb_decoder_n_scan;

  logic       clk;
  logic       rst;
  logic       enable;
  logic       mode;
  logic [2:0] addr;
  logic       load;
  logic [7:0] y;
  logic [2:0] idx;
  logic       wrap;

  logic       rst1;
  logic [0:0] addr1;
  logic [1:0] y1;
  logic [0:0] idx1;
  logic       wrap1;

  int n_total;
  int n_bad;

  decoder_n_scan #(.N(3), .DWELL(4)) u_dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_enable (enable),
    .i_mode   (mode),
    .i_addr   (addr),
    .i_load   (load),
    .o_y      (y),
    .o_idx    (idx),
    .o_wrap   (wrap)
  );

  decoder_n_scan #(.N(1), .DWELL(1)) u_dut1 (
    .i_clk    (clk),
    .i_rst    (rst1),
    .i_enable (1'b1),
    .i_mode   (1'b1),
    .i_addr   (addr1),
    .i_load   (1'b0),
    .o_y      (y1),
    .o_idx    (idx1),
    .o_wrap   (wrap1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance one rising edge and settle past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int e_idx;
    n_total = 0;
    n_bad   = 0;
    rst = 1'b1; enable = 1'b1; mode = 1'b1; addr = 3'd0; load = 1'b0;
    rst1 = 1'b1; addr1 = 1'b0;

    // Reset held two edges.
    step();
    step();
    check("rst_y", 32'(y), 32'h0);
    check("rst_idx", 32'(idx), 32'h0);
    check("rst_wrap", 32'(wrap), 32'h0);

    // Scan from reset: after edge k, idx = (k/4)%8, wrap only at k=32.
    rst = 1'b0;
    for (int k = 1; k <= 33; k++) begin
      step();
      e_idx = (k / 4) % 8;
      check("scan_y", 32'(y), 32'(1) << e_idx);
      check("scan_idx", 32'(idx), 32'(e_idx));
      check("scan_wrap", 32'(wrap), (k == 32) ? 32'h1 : 32'h0);
    end

    // Continue to edge 40: idx=2 with one dwell cycle already shown.
    for (int k = 34; k <= 40; k++) step();
    check("pre_freeze_idx", 32'(idx), 32'h2);
    check("pre_freeze_y", 32'(y), 32'h04);

    // Freeze: y dark, idx held.
    enable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("freeze_y", 32'(y), 32'h0);
      check("freeze_idx", 32'(idx), 32'h2);
    end
    // Resume: three remaining dwell cycles at idx 2, then idx 3.
    enable = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("resume_y", 32'(y), 32'h04);
    end
    step();
    check("resume_adv_y", 32'(y), 32'h08);
    check("resume_adv_idx", 32'(idx), 32'h3);

    // Advance three indices to idx 6.
    for (int k = 0; k < 12; k++) step();
    check("at6_idx", 32'(idx), 32'h6);

    // Load addr 3.
    load = 1'b1; addr = 3'd3;
    step();
    load = 1'b0;
    check("load_idx", 32'(idx), 32'h3);
    check("load_y", 32'(y), 32'h08);
    check("load_wrap", 32'(wrap), 32'h0);

    // Direct decode of 7, then back to scan: 7 held 4 cycles, then wrap.
    mode = 1'b0; addr = 3'd7;
    step();
    check("m0_y", 32'(y), 32'h80);
    mode = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("m1_hold_y", 32'(y), 32'h80);
      check("m1_hold_wrap", 32'(wrap), 32'h0);
    end
    step();
    check("m1_wrap_y", 32'(y), 32'h01);
    check("m1_wrap", 32'(wrap), 32'h1);
    step();
    check("m1_wrap_off", 32'(wrap), 32'h0);

    // Reset mid-scan at idx 5.
    load = 1'b1; addr = 3'd5;
    step();
    load = 1'b0;
    check("ld5_idx", 32'(idx), 32'h5);
    rst = 1'b1;
    step();
    check("midrst_idx", 32'(idx), 32'h0);
    check("midrst_y", 32'(y), 32'h0);
    rst = 1'b0;
    step();
    check("postrst_y", 32'(y), 32'h01);

    // Direct sweep, load must be ignored.
    mode = 1'b0; load = 1'b1;
    for (int a = 0; a < 8; a++) begin
      addr = 3'(a);
      step();
      check("dir_y", 32'(y), 32'(1) << a);
      check("dir_idx", 32'(idx), 32'(a));
      check("dir_wrap", 32'(wrap), 32'h0);
    end
    load = 1'b0;
    // 7 -> 0 in direct mode is not a wrap.
    addr = 3'd0;
    step();
    check("dir_0_y", 32'(y), 32'h01);
    check("dir_0_wrap", 32'(wrap), 32'h0);
    enable = 1'b0; addr = 3'd5;
    step();
    check("dir_dis_y", 32'(y), 32'h0);
    check("dir_dis_idx", 32'(idx), 32'h5);

    // N=1, DWELL=1: advances every edge, wrap on every return to 0.
    check("n1_rst_y", 32'(y1), 32'h0);
    rst1 = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k % 2 == 1) begin
        check("n1_y", 32'(y1), 32'h2);
        check("n1_wrap", 32'(wrap1), 32'h0);
      end else begin
        check("n1_y", 32'(y1), 32'h1);
        check("n1_wrap", 32'(wrap1), 32'h1);
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
